// File: rtl/shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : shift_scheduler
// Description : Two-requester round-robin front end sharing one iterative
//               shift/rotate engine that moves one bit position per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_scheduler (
   input  logic       clk,
   input  logic       nrst,
   input  logic       req_valid0,
   input  logic       req_valid1,
   output logic       req_ready0,
   output logic       req_ready1,
   input  logic [7:0] req_i0,
   input  logic [7:0] req_i1,
   input  logic [3:0] req_n0,
   input  logic [3:0] req_n1,
   input  logic       req_ar0,
   input  logic       req_ar1,
   input  logic       req_lr0,
   input  logic       req_lr1,
   input  logic       req_rot0,
   input  logic       req_rot1,
   output logic [7:0] o,
   output logic       o_tag,
   output logic       o_valid,
   input  logic       o_ready,
   output logic       busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0] state_q, state_d;
   logic       last_q;     // requester served most recently
   logic [3:0] cnt_q;      // remaining single-bit steps
   logic [7:0] work_q;     // word being shifted
   logic       ar_q, lr_q, rot_q;
   logic       tag_q;      // requester owning the operation in flight
   logic [7:0] o_q;
   logic       o_tag_q;

   logic       grant0, grant1, hs, sel;
   logic [7:0] sel_i;
   logic [3:0] sel_n, sel_steps;
   logic       sel_ar, sel_lr, sel_rot;
   logic [7:0] step_val;

   // Round-robin arbitration: on conflict, favour whoever was not served last
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == ST_IDLE && nrst) begin
         if (req_valid0 && req_valid1) begin
            grant0 = last_q;
            grant1 = ~last_q;
         end else begin
            grant0 = req_valid0;
            grant1 = req_valid1;
         end
      end
      hs      = grant0 | grant1;
      sel     = grant1;
      sel_i   = sel ? req_i1   : req_i0;
      sel_n   = sel ? req_n1   : req_n0;
      sel_ar  = sel ? req_ar1  : req_ar0;
      sel_lr  = sel ? req_lr1  : req_lr0;
      sel_rot = sel ? req_rot1 : req_rot0;
      // Rotation wraps modulo the word width; shifts saturate at full clear
      if (sel_rot)
         sel_steps = {1'b0, sel_n[2:0]};
      else if (sel_n > 4'd8)
         sel_steps = 4'd8;
      else
         sel_steps = sel_n;
   end

   // One-position step of the latched operation
   always_comb begin
      step_val = work_q;
      if (rot_q)
         step_val = lr_q ? {work_q[6:0], work_q[7]} : {work_q[0], work_q[7:1]};
      else if (lr_q)
         step_val = {work_q[6:0], 1'b0};
      else
         step_val = {(ar_q & work_q[7]), work_q[7:1]};
   end

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (hs)
               state_d = (sel_steps == 4'd0) ? ST_DONE : ST_SHIFT;
            else
               state_d = ST_IDLE;
         end
         ST_SHIFT: state_d = (cnt_q == 4'd1) ? ST_DONE : ST_SHIFT;
         ST_DONE:  state_d = o_ready ? ST_IDLE : ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; readiness comes straight from the arbiter
   always_comb begin
      req_ready0 = grant0;
      req_ready1 = grant1;
      o_valid    = (state_q == ST_DONE);
      busy       = (state_q != ST_IDLE);
      o          = o_q;
      o_tag      = o_tag_q;
   end

   // Operand capture, iteration and result publication
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         last_q  <= 1'b1;
         cnt_q   <= 4'd0;
         work_q  <= 8'h00;
         ar_q    <= 1'b0;
         lr_q    <= 1'b0;
         rot_q   <= 1'b0;
         tag_q   <= 1'b0;
         o_q     <= 8'h00;
         o_tag_q <= 1'b0;
      end else if (hs) begin
         last_q <= sel;
         cnt_q  <= sel_steps;
         work_q <= sel_i;
         ar_q   <= sel_ar;
         lr_q   <= sel_lr;
         rot_q  <= sel_rot;
         tag_q  <= sel;
         // Zero-step operations publish the operand unchanged right away
         if (sel_steps == 4'd0) begin
            o_q     <= sel_i;
            o_tag_q <= sel;
         end
      end else if (state_q == ST_SHIFT) begin
         work_q <= step_val;
         cnt_q  <= cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            o_q     <= step_val;
            o_tag_q <= tag_q;
         end
      end
   end

endmodule
`default_nettype wire
